// File: rtl/forward_neuron.sv
`default_nettype none
// ============================================================================
// Module  : forward_neuron
// Purpose : z = bias + sum(x_i*w_i) on one shared FP32 multiplier and adder;
//           optional hard-sigmoid activation via FORWARD_HARD_SIGMOID_EN.
// Revision: 1.0
// ============================================================================
module forward_neuron #(
  parameter int N_INPUTS = 3,
  parameter int MUL_LAT  = 1,
  parameter int ADD_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] bias,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_in,
  input  logic [31:0] w_in,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] z_out,
  output logic [31:0] a_out
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD    = 4'd1,
    MULT    = 4'd2,
    ACC     = 4'd3,
    ACT_MUL = 4'd4,
    ACT_ADD = 4'd5,
    CLAMP   = 4'd6,
    DONE    = 4'd7
  } state_t;

  localparam logic [7:0] c_MUL_LAST = 8'(MUL_LAT - 1);
  localparam logic [7:0] c_ADD_LAST = 8'(ADD_LAT - 1);
  localparam logic [8:0] c_N        = 9'(N_INPUTS);

  // Round-to-nearest-even packer; denormal results flush to zero.
  function automatic logic [31:0] fp_round(input logic s, input logic signed [9:0] e,
                                           input logic [23:0] sig, input logic g,
                                           input logic st);
    logic [24:0]       r;
    logic signed [9:0] ee;
    r  = {1'b0, sig} + {24'd0, g & (st | sig[0])};
    ee = e;
    if (r[24]) begin
      r  = r >> 1;
      ee = ee + 10'sd1;
    end
    if (ee >= 10'sd255) return {s, 8'hFF, 23'd0};
    if (ee <= 10'sd0) return {s, 31'd0};
    return {s, ee[7:0], r[22:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0]       p;
    logic signed [9:0] e;
    logic              s;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) return fp_round(s, e + 10'sd1, p[47:24], p[23], |p[22:0]);
    return fp_round(s, e, p[46:23], p[22], |p[21:0]);
  endfunction

  // Three extra bits (guard/round/sticky) below the 24-bit significand.
  function automatic logic [31:0] fp_add(input logic [31:0] a_in, input logic [31:0] b_in);
    logic [31:0]       a, b;
    logic [7:0]        d;
    logic [26:0]       ma, mb, n;
    logic [53:0]       sh;
    logic [27:0]       sum;
    logic signed [9:0] e;
    if (a_in[30:23] == 8'd0)
      return (b_in[30:23] == 8'd0) ? {a_in[31] & b_in[31], 31'd0} : b_in;
    if (b_in[30:23] == 8'd0) return a_in;
    if (a_in[30:0] < b_in[30:0]) begin
      a = b_in;
      b = a_in;
    end else begin
      a = a_in;
      b = b_in;
    end
    d  = a[30:23] - b[30:23];
    ma = {1'b1, a[22:0], 3'b000};
    sh = {1'b1, b[22:0], 3'b000, 27'd0} >> ((d > 8'd27) ? 8'd27 : d);
    mb = sh[53:27] | {26'd0, |sh[26:0]};
    e  = $signed({2'b00, a[30:23]});
    if (a[31] == b[31]) begin
      sum = {1'b0, ma} + {1'b0, mb};
      if (sum[27]) begin
        n = sum[27:1] | {26'd0, sum[0]};
        e = e + 10'sd1;
      end else begin
        n = sum[26:0];
      end
    end else begin
      n = ma - mb;
      if (n == 27'd0) return 32'd0;
      for (int i = 0; i < 26; i++) begin
        if (!n[26]) begin
          n = n << 1;
          e = e - 10'sd1;
        end
      end
    end
    return fp_round(a[31], e, n[26:3], n[2], |n[1:0]);
  endfunction

  state_t      r_state, w_next;
  logic [31:0] r_acc, r_x, r_w, r_prod;
  logic [7:0]  r_cnt, r_lat;
  logic        w_lat_last, w_timed;
  logic [31:0] w_mul_a, w_mul_b, w_add_a, w_add_b, w_mul, w_add;

`ifdef FORWARD_HARD_SIGMOID_EN
  localparam logic [31:0] c_QUARTER = 32'h3E80_0000;
  localparam logic [31:0] c_HALF    = 32'h3F00_0000;
  localparam logic [31:0] c_ONE     = 32'h3F80_0000;
  logic [31:0] r_s, r_a;
  // The single multiplier/adder pair is re-pointed at the activation constants.
  assign w_mul_a = (r_state == ACT_MUL) ? r_acc     : r_x;
  assign w_mul_b = (r_state == ACT_MUL) ? c_QUARTER : r_w;
  assign w_add_a = (r_state == ACT_ADD) ? r_prod    : r_acc;
  assign w_add_b = (r_state == ACT_ADD) ? c_HALF    : r_prod;
  assign a_out   = r_a;
`else
  assign w_mul_a = r_x;
  assign w_mul_b = r_w;
  assign w_add_a = r_acc;
  assign w_add_b = r_prod;
  assign a_out   = r_acc;
`endif

  assign w_mul = fp_mul(w_mul_a, w_mul_b);
  assign w_add = fp_add(w_add_a, w_add_b);
  assign z_out = r_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    busy       = (r_state != IDLE);
    out_valid  = 1'b0;
    w_lat_last = 1'b0;
    w_timed    = 1'b0;
    case (r_state)
      IDLE: if (start) w_next = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) w_next = MULT;
      end
      MULT: begin
        w_timed    = 1'b1;
        w_lat_last = (r_lat == c_MUL_LAST);
        if (w_lat_last) w_next = ACC;
      end
      ACC: begin
        w_timed    = 1'b1;
        w_lat_last = (r_lat == c_ADD_LAST);
        if (w_lat_last) begin
`ifdef FORWARD_HARD_SIGMOID_EN
          w_next = (({1'b0, r_cnt} + 9'd1) == c_N) ? ACT_MUL : LOAD;
`else
          w_next = (({1'b0, r_cnt} + 9'd1) == c_N) ? DONE : LOAD;
`endif
        end
      end
`ifdef FORWARD_HARD_SIGMOID_EN
      ACT_MUL: begin
        w_timed    = 1'b1;
        w_lat_last = (r_lat == c_MUL_LAST);
        if (w_lat_last) w_next = ACT_ADD;
      end
      ACT_ADD: begin
        w_timed    = 1'b1;
        w_lat_last = (r_lat == c_ADD_LAST);
        if (w_lat_last) w_next = CLAMP;
      end
      CLAMP: w_next = DONE;
`endif
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc  <= 32'd0;
      r_x    <= 32'd0;
      r_w    <= 32'd0;
      r_prod <= 32'd0;
      r_cnt  <= 8'd0;
      r_lat  <= 8'd0;
`ifdef FORWARD_HARD_SIGMOID_EN
      r_s    <= 32'd0;
      r_a    <= 32'd0;
`endif
    end else begin
      r_lat <= (w_timed && !w_lat_last) ? r_lat + 8'd1 : 8'd0;
      case (r_state)
        IDLE: if (start) begin
          r_acc <= bias;
          r_cnt <= 8'd0;
        end
        LOAD: if (in_valid) begin
          r_x <= x_in;
          r_w <= w_in;
        end
        MULT: if (w_lat_last) r_prod <= w_mul;
        ACC: if (w_lat_last) begin
          r_acc <= w_add;
          r_cnt <= r_cnt + 8'd1;
        end
`ifdef FORWARD_HARD_SIGMOID_EN
        ACT_MUL: if (w_lat_last) r_prod <= w_mul;
        ACT_ADD: if (w_lat_last) r_s <= w_add;
        CLAMP: begin
          if (r_s[31])               r_a <= 32'd0;
          else if (r_s[30:0] >= c_ONE[30:0]) r_a <= c_ONE;
          else                        r_a <= r_s;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_forward_neuron.sv
`default_nettype none
// Bench for forward_neuron: directed scenarios plus randomized evaluations checked
// against a real-arithmetic reference model (operands chosen so results are exact).
module tb_forward_neuron;
  localparam int N  = 3;
  localparam int ML = 1;
  localparam int AL = 1;
`ifdef FORWARD_HARD_SIGMOID_EN
  localparam int LAT = 1 + N * (1 + ML + AL) + ML + AL + 1;
`else
  localparam int LAT = 1 + N * (1 + ML + AL);
`endif

  logic        clk = 1'b0;
  logic        reset, start, in_valid, out_ready;
  logic [31:0] bias, x_in, w_in;
  logic        in_ready, busy, out_valid;
  logic [31:0] z_out, a_out;

  int  checks = 0;
  int  failures = 0;
  real br;
  real xs[N];
  real ws[N];
  int  stall[N];

  always #5 clk = ~clk;

  forward_neuron #(.N_INPUTS(N), .MUL_LAT(ML), .ADD_LAT(AL)) dut (
    .clk(clk), .reset(reset), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .w_in(w_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .z_out(z_out), .a_out(a_out)
  );

  // Exact real -> single conversion (all bench values are exactly representable).
  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic real model_acc();
    real acc;
    acc = br;
    for (int i = 0; i < N; i++) acc = acc + xs[i] * ws[i];
    return acc;
  endfunction

  function automatic logic [31:0] model_a();
`ifdef FORWARD_HARD_SIGMOID_EN
    real s;
    s = model_acc() * 0.25 + 0.5;
    if (s < 0.0) return 32'd0;
    if (s >= 1.0) return 32'h3F800000;
    return r2sp(s);
`else
    return r2sp(model_acc());
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_eval(input string tag, input int hold, input bit start_in_done,
                          output logic [31:0] zo, output logic [31:0] ao);
    int t, p, stalls_left, lat, total_stall;
    bit leak, stable, prev_xfer, done_seen;
    total_stall = 0;
    for (int i = 0; i < N; i++) total_stall += stall[i];
    @(negedge clk);
    bias = r2sp(br); start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    t = 0; p = 0; stalls_left = stall[0]; lat = -1;
    leak = 1'b0; prev_xfer = 1'b0; done_seen = 1'b0;
    while (t < LAT + total_stall + 50 && !done_seen) begin
      @(negedge clk);
      t++;
      start = 1'b0;
      if (out_valid) begin
        done_seen = 1'b1;
        lat = t;
        if (in_ready) leak = 1'b1;
      end else begin
        if (prev_xfer && in_ready) leak = 1'b1;
        prev_xfer = 1'b0;
        in_valid  = 1'b0;
        if (in_ready) begin
          if (p >= N) leak = 1'b1;
          else if (stalls_left > 0) stalls_left--;
          else begin
            x_in = r2sp(xs[p]); w_in = r2sp(ws[p]);
            in_valid = 1'b1; prev_xfer = 1'b1;
            p++;
            if (p < N) stalls_left = stall[p];
          end
        end
      end
    end
    in_valid = 1'b0;
    check({tag, "_done_seen"}, {31'd0, done_seen}, 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(LAT + total_stall));
    check({tag, "_ready_leak"}, {31'd0, leak}, 32'd0);
    zo = z_out;
    ao = a_out;
    check({tag, "_z"}, zo, r2sp(model_acc()));
    check({tag, "_a"}, ao, model_a());
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      start = start_in_done && (i == 0);
      @(negedge clk);
      if (!out_valid || z_out !== zo || a_out !== ao) stable = 1'b0;
    end
    check({tag, "_hold_stable"}, {31'd0, stable}, 32'd1);
    out_ready = 1'b1;
    start = start_in_done;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    if (start_in_done) begin
      repeat (3) @(negedge clk);
      check({tag, "_start_ignored"}, {30'd0, busy, out_valid}, 32'd0);
    end
  endtask

  task automatic set_first();
    br = 0.0;
    for (int i = 0; i < N; i++) begin
      xs[i] = 1.0; ws[i] = 0.5; stall[i] = 0;
    end
  endtask

  initial begin
    logic [31:0] zr, ar;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    bias = 32'd0; x_in = 32'd0; w_in = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_flags", {29'd0, busy, in_ready, out_valid}, 32'd0);
    check("rst_z", z_out, 32'd0);
    check("rst_a", a_out, 32'd0);
    reset = 1'b0;

    set_first();
    run_eval("s1", 0, 1'b0, zr, ar);
    check("s1_z_lit", zr, 32'h3FC00000);
`ifdef FORWARD_HARD_SIGMOID_EN
    check("s1_a_lit", ar, 32'h3F600000);
`else
    check("s1_a_lit", ar, 32'h3FC00000);
`endif

    for (int i = 0; i < N; i++) begin xs[i] = 0.0; ws[i] = 1.0; end
    br = -4.0;
    run_eval("neg4", 0, 1'b0, zr, ar);
    check("neg4_z_lit", zr, 32'hC0800000);
`ifdef FORWARD_HARD_SIGMOID_EN
    check("neg4_a_lit", ar, 32'h00000000);
`endif
    br = 4.0;
    run_eval("pos4", 0, 1'b0, zr, ar);
`ifdef FORWARD_HARD_SIGMOID_EN
    check("pos4_a_lit", ar, 32'h3F800000);
`else
    check("pos4_a_lit", ar, 32'h40800000);
`endif
    br = 2.0;  run_eval("edge_hi", 0, 1'b0, zr, ar);
    br = -2.0; run_eval("edge_lo", 0, 1'b0, zr, ar);

    set_first();
    stall[1] = 5;
    run_eval("stall", 0, 1'b0, zr, ar);
    check("stall_z_lit", zr, 32'h3FC00000);

    set_first();
    run_eval("hold", 10, 1'b1, zr, ar);

    // Reset while the second pair is in MULT.
    set_first();
    @(negedge clk);
    bias = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; x_in = r2sp(1.0); w_in = r2sp(0.5);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_mult_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_flags", {29'd0, busy, in_ready, out_valid}, 32'd0);
    check("mid_rst_z", z_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_rst_no_out", {30'd0, busy, out_valid}, 32'd0);
    run_eval("after_rst", 0, 1'b0, zr, ar);
    check("after_rst_z_lit", zr, 32'h3FC00000);

    for (int n = 0; n < 25; n++) begin
      br = real'(int'($urandom_range(30)) - 15) / 4.0;
      for (int i = 0; i < N; i++) begin
        xs[i] = real'(int'($urandom_range(30)) - 15) / 4.0;
        ws[i] = real'(int'($urandom_range(30)) - 15) / 4.0;
        stall[i] = ($urandom_range(3) == 0) ? int'($urandom_range(4)) : 0;
      end
      run_eval($sformatf("rnd%0d", n), int'($urandom_range(4)), 1'($urandom_range(1)), zr, ar);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
